// File: rtl/ureg_pkg.sv
// Shared types and encodings for the universal-register sequencer: FSM states,
// command opcodes and register mode constants.
package ureg_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StShift   = 3'd2,
        StCapture = 3'd3,
        StResp    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OpShiftOut = 2'b00,
        OpShiftIn  = 2'b01,
        OpWrite    = 2'b10,
        OpRead     = 2'b11
    } cmd_op_e;

    localparam logic [1:0] ModeSiso = 2'b00;
    localparam logic [1:0] ModeSipo = 2'b01;
    localparam logic [1:0] ModePiso = 2'b10;
    localparam logic [1:0] ModePipo = 2'b11;

    localparam int unsigned CntW = 6;

    // Encodings above StResp are unreachable and treated as corruption.
    function automatic logic state_legal(logic [2:0] s);
        return s <= 3'd4;
    endfunction

endpackage

// File: rtl/tmr_voter3.sv
// Bitwise 2-of-3 majority voter with a disagreement flag.
module tmr_voter3 #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] c_i,
    output logic [Width-1:0] y_o,
    output logic             mismatch_o
);

    assign y_o        = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign mismatch_o = (a_i != b_i) || (a_i != c_i);

endmodule

// File: rtl/ureg_seq_ctrl.sv
// Command sequencer for an external universal shift register, with a
// triplicated, scrubbed state register.
module ureg_seq_ctrl
    import ureg_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [5:0]       cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             reg_enable,
    output logic [1:0]       reg_mode,
    output logic             reg_load,
    output logic             reg_serial_in,
    output logic [WIDTH-1:0] reg_parallel_in,
    input  logic             reg_serial_out,
    input  logic [WIDTH-1:0] reg_parallel_out,
    output logic             busy,
    output logic             fsm_err
);

    state_e           st_a_q, st_b_q, st_c_q, st_d, cur_st;
    logic [2:0]       st_vote;
    logic             st_mismatch, st_ok;

    cmd_op_e          op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             fsm_err_q, fsm_err_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             reg_enable_q, reg_enable_d;
    logic             reg_load_q, reg_load_d;
    logic [1:0]       reg_mode_q, reg_mode_d;
    logic [WIDTH-1:0] reg_pin_q, reg_pin_d;
    logic             shift_out_q, shift_out_d;
    logic             shift_in_q, shift_in_d;

    tmr_voter3 #(
        .Width(3)
    ) u_state_voter (
        .a_i       (st_a_q),
        .b_i       (st_b_q),
        .c_i       (st_c_q),
        .y_o       (st_vote),
        .mismatch_o(st_mismatch)
    );

    assign st_ok  = state_legal(st_vote);
    assign cur_st = state_e'(st_vote);

    always_comb begin
        st_d       = cur_st;
        op_d       = op_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        fsm_err_d  = fsm_err_q | st_mismatch;

        if (!st_ok) begin
            st_d      = StIdle;
            fsm_err_d = 1'b1;
        end else begin
            unique case (cur_st)
                StIdle: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_d   = cmd_op_e'(cmd_op);
                        data_d = cmd_data;
                        cnt_d  = (cmd_len == '0) ? CntW'(32) : cmd_len;
                        cap_d  = '0;
                        unique case (cmd_op_e'(cmd_op))
                            OpShiftOut, OpWrite: st_d = StLoad;
                            OpShiftIn:           st_d = StShift;
                            OpRead:              st_d = StCapture;
                        endcase
                    end
                end
                StLoad: st_d = (op_q == OpWrite) ? StCapture : StShift;
                StShift: begin
                    cnt_d = cnt_q - CntW'(1);
                    if (op_q == OpShiftOut) begin
                        cap_d = {cap_q[WIDTH-2:0], reg_serial_out};
                    end
                    if (cnt_q == CntW'(1)) begin
                        if (op_q == OpShiftOut) begin
                            st_d       = StResp;
                            rsp_data_d = cap_d;
                        end else begin
                            st_d = StCapture;
                        end
                    end
                end
                StCapture: begin
                    rsp_data_d = reg_parallel_out;
                    st_d       = StResp;
                end
                StResp: if (rsp_ready) st_d = StIdle;
                default: st_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state copies.
    always_comb begin
        reg_enable_d = (st_d == StLoad) || (st_d == StShift);
        reg_load_d   = (st_d == StLoad);
        reg_pin_d    = (st_d == StLoad) ? data_d : '0;
        reg_mode_d   = reg_mode_q;
        if (st_d == StLoad) begin
            reg_mode_d = (op_d == OpWrite) ? ModePipo : ModePiso;
        end else if (st_d == StShift) begin
            reg_mode_d = (op_d == OpShiftOut) ? ModePiso : ModeSipo;
        end
        shift_out_d = (st_d == StShift) && (op_d == OpShiftOut);
        shift_in_d  = (st_d == StShift) && (op_d == OpShiftIn);
        rsp_valid_d = (st_d == StResp);
        busy_d      = (st_d != StIdle);
        cmd_ready_d = (st_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_a_q       <= StIdle;
            st_b_q       <= StIdle;
            st_c_q       <= StIdle;
            op_q         <= OpShiftOut;
            data_q       <= '0;
            cnt_q        <= '0;
            cap_q        <= '0;
            rsp_data_q   <= '0;
            fsm_err_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            reg_enable_q <= 1'b0;
            reg_load_q   <= 1'b0;
            reg_mode_q   <= ModeSiso;
            reg_pin_q    <= '0;
            shift_out_q  <= 1'b0;
            shift_in_q   <= 1'b0;
        end else begin
            st_a_q       <= st_d;
            st_b_q       <= st_d;
            st_c_q       <= st_d;
            op_q         <= op_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            rsp_data_q   <= rsp_data_d;
            fsm_err_q    <= fsm_err_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            reg_enable_q <= reg_enable_d;
            reg_load_q   <= reg_load_d;
            reg_mode_q   <= reg_mode_d;
            reg_pin_q    <= reg_pin_d;
            shift_out_q  <= shift_out_d;
            shift_in_q   <= shift_in_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign rsp_valid       = rsp_valid_q && st_ok;
    assign rsp_data        = rsp_data_q;
    assign fsm_err         = fsm_err_q;
    assign reg_enable      = reg_enable_q;
    assign reg_load        = reg_load_q;
    assign reg_mode        = reg_mode_q;
    assign reg_parallel_in = reg_pin_q;
    assign ser_out         = shift_out_q & reg_serial_out;
    assign reg_serial_in   = shift_in_q & ser_in;

endmodule

// File: tb/tb_ureg_seq_ctrl.sv
// Bench for ureg_seq_ctrl: behavioural universal register (LSB-first serial
// port, serial input enters at the MSB) plus a response scoreboard.
module tb_ureg_seq_ctrl;
    import ureg_pkg::*;

    localparam int W = 32;

    logic         clk, rst;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [5:0]   cmd_len;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_data;
    logic         ser_in, ser_out;
    logic         reg_enable, reg_load, reg_serial_in, reg_serial_out;
    logic [1:0]   reg_mode;
    logic [W-1:0] reg_parallel_in, reg_parallel_out;
    logic         busy, fsm_err;

    logic [W-1:0] rm_q;
    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    ureg_seq_ctrl #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .cmd_len         (cmd_len),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .ser_in          (ser_in),
        .ser_out         (ser_out),
        .reg_enable      (reg_enable),
        .reg_mode        (reg_mode),
        .reg_load        (reg_load),
        .reg_serial_in   (reg_serial_in),
        .reg_parallel_in (reg_parallel_in),
        .reg_serial_out  (reg_serial_out),
        .reg_parallel_out(reg_parallel_out),
        .busy            (busy),
        .fsm_err         (fsm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) rm_q <= '0;
        else if (reg_enable) begin
            if (reg_load) rm_q <= reg_parallel_in;
            else case (reg_mode)
                2'b00, 2'b01: rm_q <= {reg_serial_in, rm_q[W-1:1]};
                2'b10:        rm_q <= {1'b0, rm_q[W-1:1]};
                default:      rm_q <= rm_q;
            endcase
        end
    end
    assign reg_serial_out   = rm_q[0];
    assign reg_parallel_out = rm_q;

    function automatic logic [W-1:0] rev_low(input logic [W-1:0] d, input int n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[W-2:0], d[i]};
        return r;
    endfunction

    // Runs one command from a negedge; returns latency and register-control statistics.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [5:0] len,
                           input int stall, input int tmr_at, input bit spam,
                           output int lat, output int n_load, output int n_shift,
                           output logic [1:0] mode, output int bad);
        int nsh = 0;
        bit got = 0;
        logic [W-1:0] held = '0;
        logic [W-1:0] exp;
        lat = 0; n_load = 0; n_shift = 0; mode = 2'b00; bad = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_len = len;
        @(negedge clk);
        if (spam) begin
            cmd_op = ~op; cmd_data = ~data; cmd_len = 6'd3;
        end else cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
            if (tmr_at > 0 && cyc == tmr_at) force dut.st_b_q = StResp;
            if (tmr_at > 0 && cyc == tmr_at + 1) release dut.st_b_q;
            if (reg_enable && reg_load) begin
                n_load++;
                mode = reg_mode;
            end
            if (reg_enable && !reg_load) begin
                if (n_shift > 0 && reg_mode !== mode) bad++;
                n_shift++;
                mode = reg_mode;
                if (op == OpShiftOut && nsh < W && ser_out !== data[nsh]) bad++;
                ser_in = ~nsh[0];
                nsh++;
            end else begin
                ser_in = 1'b1;
                if (ser_out !== 1'b0 || reg_serial_in !== 1'b0) bad++;
                if (!reg_enable && reg_parallel_in !== '0) bad++;
            end
            if (rsp_valid) begin
                if (lat == 0) begin
                    lat  = cyc;
                    held = rsp_data;
                end
                if (cyc - lat < stall) begin
                    rsp_ready = 1'b0;
                    if (rsp_data !== held || cmd_ready !== 1'b0) bad++;
                end else begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL scoreboard_empty: got rsp %h, required no response", rsp_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (rsp_data !== exp) begin
                            n_err++;
                            $display("FAIL rsp_data op=%0d: got %h, required %h", op, rsp_data, exp);
                        end
                    end
                    rsp_ready = 1'b1;
                    cmd_valid = 1'b0;
                    got = 1;
                end
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        ser_in    = 1'b0;
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout op=%0d: got no response, required one", op);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_vec++; if (rsp_valid !== 1'b0 || rsp_data !== '0) begin
            n_err++; $display("FAIL reset_rsp: got %b/%h, required 0/0", rsp_valid, rsp_data);
        end
        n_vec++; if ({reg_enable, reg_load, reg_mode, reg_serial_in} !== 5'b0) begin
            n_err++; $display("FAIL reset_reg_ctrl: got %b%b%b%b, required 00000",
                              reg_enable, reg_load, reg_mode, reg_serial_in);
        end
        n_vec++; if (reg_parallel_in !== '0 || ser_out !== 1'b0) begin
            n_err++; $display("FAIL reset_pin_ser: got %h/%b, required 0/0", reg_parallel_in, ser_out);
        end
        n_vec++; if (fsm_err !== 1'b0) begin n_err++; $display("FAIL reset_fsm_err: got %b, required 0", fsm_err); end
    endtask

    task automatic test_write_read();
        int lat, nl, ns, bad;
        logic [1:0] md;
        exp_q.push_back(32'hA5A5_0F0F);
        run_cmd(OpWrite, 32'hA5A5_0F0F, 6'd0, 0, 0, 0, lat, nl, ns, md, bad);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL write_latency: got %0d, required 3", lat); end
        n_vec++; if (nl != 1 || ns != 0) begin n_err++; $display("FAIL write_load: got load=%0d shift=%0d, required 1/0", nl, ns); end
        n_vec++; if (md !== ModePipo) begin n_err++; $display("FAIL write_mode: got %b, required 11", md); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL write_ctrl: got %0d bad cycles, required 0", bad); end
        n_vec++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL write_idle: got ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
        exp_q.push_back(32'hA5A5_0F0F);
        run_cmd(OpRead, 32'h0, 6'd0, 0, 0, 0, lat, nl, ns, md, bad);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL read_latency: got %0d, required 2", lat); end
        n_vec++; if (nl != 0 || ns != 0 || bad != 0) begin
            n_err++; $display("FAIL read_ctrl: got load=%0d shift=%0d bad=%0d, required 0/0/0", nl, ns, bad);
        end
    endtask

    task automatic test_shift_out();
        int lat, nl, ns, bad;
        logic [1:0] md;
        exp_q.push_back(32'h0000_00AD);
        run_cmd(OpShiftOut, 32'h0000_00B5, 6'd8, 0, 0, 0, lat, nl, ns, md, bad);
        n_vec++; if (nl != 1 || ns != 8) begin n_err++; $display("FAIL shout_counts: got load=%0d shift=%0d, required 1/8", nl, ns); end
        n_vec++; if (md !== ModePiso) begin n_err++; $display("FAIL shout_mode: got %b, required 10", md); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL shout_ser_out: got %0d bad cycles, required 0", bad); end
        n_vec++; if (lat != 10) begin n_err++; $display("FAIL shout_latency: got %0d, required 10", lat); end
    endtask

    task automatic test_shift_in();
        int lat, nl, ns, bad;
        logic [1:0] md;
        exp_q.push_back(32'h5555_5555);
        run_cmd(OpShiftIn, 32'h0, 6'd0, 0, 0, 0, lat, nl, ns, md, bad);
        n_vec++; if (nl != 0 || ns != 32) begin n_err++; $display("FAIL shin_counts: got load=%0d shift=%0d, required 0/32", nl, ns); end
        n_vec++; if (md !== ModeSipo) begin n_err++; $display("FAIL shin_mode: got %b, required 01", md); end
        n_vec++; if (lat != 34) begin n_err++; $display("FAIL shin_latency: got %0d, required 34", lat); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL shin_ctrl: got %0d bad cycles, required 0", bad); end
    endtask

    task automatic test_tmr();
        int lat, nl, ns, bad;
        logic [1:0] md;
        exp_q.push_back(rev_low(32'h1234_C3A5, 16));
        run_cmd(OpShiftOut, 32'h1234_C3A5, 6'd16, 0, 5, 0, lat, nl, ns, md, bad);
        n_vec++; if (lat != 18 || ns != 16 || bad != 0) begin
            n_err++; $display("FAIL tmr_complete: got lat=%0d shift=%0d bad=%0d, required 18/16/0", lat, ns, bad);
        end
        n_vec++; if (fsm_err !== 1'b1) begin n_err++; $display("FAIL tmr_err_set: got %b, required 1", fsm_err); end
        exp_q.push_back(32'h0BAD_F00D);
        run_cmd(OpWrite, 32'h0BAD_F00D, 6'd0, 0, 0, 0, lat, nl, ns, md, bad);
        n_vec++; if (fsm_err !== 1'b1) begin n_err++; $display("FAIL tmr_err_sticky: got %b, required 1", fsm_err); end
    endtask

    task automatic test_backpressure();
        int lat, nl, ns, bad;
        logic [1:0] md;
        exp_q.push_back(32'hDEAD_BEEF);
        run_cmd(OpWrite, 32'hDEAD_BEEF, 6'd0, 5, 0, 1, lat, nl, ns, md, bad);
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d bad cycles, required 0", bad); end
        n_vec++; if (lat != 3 || ns != 0) begin n_err++; $display("FAIL bp_ignore_cmd: got lat=%0d shift=%0d, required 3/0", lat, ns); end
        exp_q.push_back(32'hDEAD_BEEF);
        run_cmd(OpRead, 32'h0, 6'd0, 0, 0, 0, lat, nl, ns, md, bad);
    endtask

    task automatic test_abort();
        int stray = 0;
        cmd_valid = 1'b1; cmd_op = OpShiftIn; cmd_data = '0; cmd_len = 6'd20;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (reg_enable !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL abort_in_shift: got en=%b busy=%b, required 1/1", reg_enable, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (reg_enable !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL abort_idle: got en=%b rv=%b busy=%b rdy=%b, required 0/0/0/1",
                              reg_enable, rsp_valid, busy, cmd_ready);
        end
        n_vec++; if (fsm_err !== 1'b0) begin n_err++; $display("FAIL abort_err_clear: got %b, required 0", fsm_err); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || reg_enable !== 1'b0) stray++;
        end
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL abort_no_rsp: got %0d active cycles, required 0", stray); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_len = '0;
        rsp_ready = 1'b0; ser_in = 1'b0;
        test_reset();
        test_write_read();
        test_shift_out();
        test_shift_in();
        test_tmr();
        test_backpressure();
        test_abort();
        n_vec++; if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ureg_seq_ctrl.md
UREG_SEQ_CTRL -- requirements
Module: ureg_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the controlled universal register.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have input cmd_valid, 1 bit, which marks a command as present.
REQ-005 The block SHALL have output cmd_ready, 1 bit, which signals that a command can be accepted.
REQ-006 The block SHALL have input cmd_op, 2 bits: 00 SHIFT_OUT, 01 SHIFT_IN, 10 WRITE, 11 READ.
REQ-007 The block SHALL have input cmd_data, WIDTH bits, the word to load for SHIFT_OUT and WRITE.
REQ-008 The block SHALL have input cmd_len, 6 bits, the shift count 1..32, where 0 means 32.
REQ-009 The block SHALL have output rsp_valid, 1 bit, which marks the response as present.
REQ-010 The block SHALL have input rsp_ready, 1 bit, which signals that the consumer takes the response.
REQ-011 The block SHALL have output rsp_data, WIDTH bits, the result word.
REQ-012 The block SHALL have input ser_in, 1 bit, the external serial source for SHIFT_IN.
REQ-013 The block SHALL have output ser_out, 1 bit, the external serial sink for SHIFT_OUT.
REQ-014 The block SHALL drive the register control outputs reg_enable (1 bit), reg_mode (2 bits), reg_load (1 bit), reg_serial_in (1 bit) and reg_parallel_in (WIDTH bits).
REQ-015 The block SHALL take the register status inputs reg_serial_out (1 bit) and reg_parallel_out (WIDTH bits).
REQ-016 The block SHALL have outputs busy (1 bit, high whenever the state is not IDLE) and fsm_err (1 bit, sticky flag for a TMR state-copy mismatch).

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, SHIFT, CAPTURE and RESP; cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on cmd_valid&cmd_ready.
REQ-018 On accept, the block SHALL latch op, data and len, and SHALL load the bit counter with len (0 becomes 32).
REQ-019 The next state after accept SHALL be LOAD for SHIFT_OUT and WRITE, SHIFT for SHIFT_IN, and CAPTURE for READ.
REQ-020 LOAD SHALL last 1 cycle with reg_enable=1, reg_load=1, reg_parallel_in=latched data, and reg_mode=10 (PISO) for SHIFT_OUT or 11 (PIPO) for WRITE; it SHALL then go to SHIFT for SHIFT_OUT and to CAPTURE for WRITE.
REQ-021 Each SHIFT cycle SHALL drive reg_enable=1 and reg_load=0, with reg_mode=10 for SHIFT_OUT and 01 (SIPO) for SHIFT_IN, and SHALL decrement the counter; SHIFT SHALL exit after the cycle in which the counter equals 1, so exactly len cycles.
REQ-022 For SHIFT_OUT, in each SHIFT cycle ser_out SHALL equal reg_serial_out and the capture register SHALL update as cap <= {cap[WIDTH-2:0], reg_serial_out}; the next state SHALL then be RESP with rsp_data=cap, whose upper bits are 0 when len<32.
REQ-023 For SHIFT_IN, reg_serial_in SHALL equal ser_in in each SHIFT cycle, and the next state SHALL be CAPTURE.
REQ-024 CAPTURE SHALL last 1 cycle with reg_enable=0, SHALL register rsp_data from reg_parallel_out, and SHALL go to RESP.
REQ-025 RESP SHALL drive rsp_valid=1 and SHALL hold rsp_data stable until rsp_ready; on the handshake cycle the next state SHALL be IDLE.
REQ-026 Outside LOAD and SHIFT, reg_enable, reg_load, reg_serial_in, reg_parallel_in and ser_out SHALL be 0 and reg_mode SHALL hold its last value.
REQ-027 WRITE SHALL assert rsp_valid on the 3rd cycle after the accept edge, and READ on the 2nd.
REQ-028 If cmd_valid is high outside IDLE, it SHALL be ignored with no side effects.
REQ-029 The state register SHALL be triplicated and majority-voted every cycle, and the voted next state SHALL be written to all three copies (scrubbing).
REQ-030 Any copy disagreement SHALL set fsm_err until rst, while operation continues on the voted value.
REQ-031 An illegal voted encoding SHALL force IDLE, set fsm_err and drop rsp_valid.

Reset
REQ-032 While rst=1 at an edge, the FSM SHALL go to IDLE in all three copies; counter, cap, rsp_data and fsm_err SHALL be cleared; all outputs SHALL be 0 except cmd_ready=1 in the cycle after.
REQ-033 A reset during an active command SHALL abort it, with no response issued and the register control outputs at 0 from the next cycle.

Structure
REQ-034 A shared package ureg_pkg SHALL hold the FSM state enum, the cmd_op encodings and the reg_mode constants (SISO 00, SIPO 01, PISO 10, PIPO 11).
REQ-035 The bitwise majority voter SHALL be a separate sub-module tmr_voter3, parameterised by width, which also outputs a mismatch flag.

Verification
REQ-036 Reset check: assert rst for 2 cycles, then release -> all outputs 0, cmd_ready=1, busy=0.
REQ-037 WRITE directed test: WRITE with data 0xA5A50F0F -> one LOAD cycle (mode 11, load 1); rsp_valid 3 cycles after accept; rsp_data 0xA5A50F0F from the register model.
REQ-038 SHIFT_OUT directed test: SHIFT_OUT with len=8 and data 0x000000B5 -> 1 LOAD cycle then exactly 8 reg_enable cycles in mode 10; ser_out sequence matches the model; rsp_data[31:8]=0.
REQ-039 SHIFT_IN directed test: SHIFT_IN with len=0 and ser_in alternating 1,0 -> 32 SHIFT cycles, 1 CAPTURE cycle, rsp_data 0xAAAAAAAA (or 0x55555555 per the register model's shift direction).
REQ-040 TMR directed test: force one state copy to RESP during SHIFT for 1 cycle -> the command completes correctly and fsm_err=1 until rst.
REQ-041 Abort and backpressure test: assert rst mid-SHIFT -> IDLE next cycle with reg_enable=0 and no rsp_valid; separately, hold rsp_ready=0 for 5 cycles -> rsp_data stable and cmd_ready=0.
